spi_shift_engine: RTL and testbench
===================================

Name: spi_shift_engine

Overview:
- Parametrised successor to the fixed 8-bit parallel-load/serial-in shift register used in the SPI bring-up path.
- Adds a generic width, selectable MSB/LSB-first order, a bit counter, word-complete detection, and a one-deep receive buffer with valid/ack/overrun.
- Sits between the input conditioners (which supply a single-cycle peripheral clock edge pulse and serial data) and the LED/GPIO or downstream consumer logic.

Parameters:
- WIDTH, 8: shift register and receive buffer width in bits; must be at least 2.
- COUNT_WIDTH, 3: bit counter width; requires 2^COUNT_WIDTH >= WIDTH.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- periph_clk_edge  input  1  single-cycle pulse from a conditioner; one shift per pulse.
- parallel_load  input  1  single-cycle pulse; loads parallel_in.
- parallel_in  input  WIDTH  value captured on load.
- lsb_first  input  1  shift-order mode; sampled only on load.
- serial_in  input  1  conditioned serial data, sampled on a shift.
- rx_ack  input  1  consumer acknowledges rx_data.
- serial_out  output  1  current outgoing bit.
- parallel_out  output  WIDTH  live shift register contents.
- bit_count  output  COUNT_WIDTH  bits shifted in the current word, 0..WIDTH-1.
- word_done  output  1  one-cycle pulse when a word completes.
- rx_data  output  WIDTH  last completed word.
- rx_valid  output  1  rx_data holds an unacknowledged word.
- overrun  output  1  sticky flag: a word completed while rx_valid was already set.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset. All state updates occur on posedge clk.
- Reset values: shreg=0, mode=MSB-first, bit_count=0, word_done=0, rx_data=0, rx_valid=0, overrun=0, serial_out=0. Reset overrides every other input, including when asserted mid-word.
- Load: when parallel_load=1, set shreg<=parallel_in, mode<=lsb_first, and bit_count<=0. Load has priority over a coincident periph_clk_edge; that edge is dropped with no shift and no count. rx_* state is unaffected by a load.
- Shift, MSB-first (mode=0): on periph_clk_edge with no load, shreg<={shreg[WIDTH-2:0],serial_in}. serial_out=shreg[WIDTH-1].
- Shift, LSB-first (mode=1): on periph_clk_edge with no load, shreg<={serial_in,shreg[WIDTH-1:1]}. serial_out=shreg[0].
- serial_out is combinational from the registered shreg and mode, so it shows the next bit in the cycle after each shift.
- Latency: a pulse in cycle N updates parallel_out and bit_count in cycle N+1.
- Counter:
  - Each shift increments bit_count.
  - A shift with bit_count==WIDTH-1 wraps bit_count to 0 and completes the word.
  - Shifting is free-running; no load is required between words.
- Word completion, registered in the same edge as the final shift:
  - word_done=1 for exactly one cycle.
  - rx_data<=new shreg value, i.e. the post-shift value, equal to parallel_out in that cycle.
  - rx_valid<=1.
- Receive handshake:
  - rx_ack with no completion clears rx_valid and overrun.
  - Completion while rx_valid=1 and rx_ack=0 overwrites rx_data and sets overrun=1.
  - Completion coincident with rx_ack: rx_data is updated, rx_valid stays 1, overrun is cleared, not set.
  - rx_ack while rx_valid=0 has no effect.
- Held inputs: periph_clk_edge and parallel_load are treated as pulses, but if held high they act once per clk cycle. Edge detection is the conditioner's job.

Test Plan (WIDTH=8 unless stated):
1. Reset, then load 0xA5 with lsb_first=0, then 8 edges with serial_in following 0x3C MSB-first (0,0,1,1,1,1,0,0) -> serial_out sequence 1,0,1,0,0,1,0,1; bit_count steps 1..7,0; word_done high one cycle; rx_data=0x3C; rx_valid=1; overrun=0.
2. Load 0x0F with lsb_first=1, serial_in=1 for 8 edges -> serial_out sequence 1,1,1,1,0,0,0,0; rx_data=0xFF. Then rx_ack -> rx_valid=0.
3. Two full words 0x12 then 0x34 with no rx_ack -> after the second word, rx_data=0x34, rx_valid=1, overrun=1. rx_ack -> both cleared. Repeat with rx_ack coincident with the completing edge -> rx_valid=1, overrun=0.
4. parallel_load=0x5A and periph_clk_edge in the same cycle -> parallel_out=0x5A and bit_count=0, with no shift.
5. After 3 edges, assert reset for 1 cycle -> all outputs 0. Then load 0xC3 and give 8 edges -> word_done only after the 8th edge.
6. Instance with WIDTH=12, COUNT_WIDTH=4: load 0xABC MSB-first, 12 edges with serial_in=0 -> serial_out sequence follows 1010_1011_1100; word_done on the 12th edge; rx_data=0x000.

Source files
------------

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: parametrised SPI shift register with bit counter,
// word-complete detection and a one-deep receive buffer.
//
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   periph_clk_edge   - one shift per cycle it is high
//   parallel_load     - load parallel_in / lsb_first, clear bit counter
//   parallel_in       - value captured on load
//   lsb_first         - shift order, captured on load
//   serial_in         - serial data sampled on a shift
//   rx_ack            - consumer acknowledge of rx_data
//   serial_out        - current outgoing bit (combinational from shreg/mode)
//   parallel_out      - live shift register contents
//   bit_count         - bits shifted in the current word
//   word_done         - one-cycle pulse on word completion
//   rx_data           - last completed word
//   rx_valid          - rx_data holds an unacknowledged word
//   overrun           - sticky: a word completed while rx_valid was set
module spi_shift_engine #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned COUNT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   periph_clk_edge,
    input  logic                   parallel_load,
    input  logic [WIDTH-1:0]       parallel_in,
    input  logic                   lsb_first,
    input  logic                   serial_in,
    input  logic                   rx_ack,
    output logic                   serial_out,
    output logic [WIDTH-1:0]       parallel_out,
    output logic [COUNT_WIDTH-1:0] bit_count,
    output logic                   word_done,
    output logic [WIDTH-1:0]       rx_data,
    output logic                   rx_valid,
    output logic                   overrun
);

    localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic             mode;
    logic [WIDTH-1:0] shreg_next;
    logic             do_shift;
    logic             complete;

    // Next shift register value for the current mode
    always_comb begin
        shreg_next = shreg;
        if (mode) begin
            shreg_next = {serial_in, shreg[WIDTH-1:1]};
        end else begin
            shreg_next = {shreg[WIDTH-2:0], serial_in};
        end
    end

    // A load swallows a coincident edge
    assign do_shift = periph_clk_edge && !parallel_load;
    assign complete = do_shift && (bit_count == LAST_BIT);

    // Shift register, mode and bit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            mode      <= 1'b0;
            bit_count <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= complete;
            if (parallel_load) begin
                shreg     <= parallel_in;
                mode      <= lsb_first;
                bit_count <= '0;
            end else if (do_shift) begin
                shreg     <= shreg_next;
                bit_count <= complete ? '0 : bit_count + COUNT_WIDTH'(1);
            end
        end
    end

    // Receive buffer: completion wins over ack; ack alongside completion
    // still clears any pending overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (complete) begin
            rx_data  <= shreg_next;
            rx_valid <= 1'b1;
            if (rx_ack) begin
                overrun <= 1'b0;
            end else if (rx_valid) begin
                overrun <= 1'b1;
            end
        end else if (rx_ack && rx_valid) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

    assign serial_out   = mode ? shreg[0] : shreg[WIDTH-1];
    assign parallel_out = shreg;

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed-vector bench for spi_shift_engine at
// WIDTH=8 and WIDTH=12/COUNT_WIDTH=4.
module tb_spi_shift_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       edge_p = 1'b0;
    logic       load = 1'b0;
    logic [7:0] pin = '0;
    logic       lsb = 1'b0;
    logic       sin = 1'b0;
    logic       ack = 1'b0;
    logic       sout;
    logic [7:0] pout;
    logic [2:0] bcnt;
    logic       wdone;
    logic [7:0] rxd;
    logic       rxv;
    logic       ovr;

    logic        w_edge = 1'b0;
    logic        w_load = 1'b0;
    logic [11:0] w_pin = '0;
    logic        w_lsb = 1'b0;
    logic        w_sin = 1'b0;
    logic        w_ack = 1'b0;
    logic        w_sout;
    logic [11:0] w_pout;
    logic [3:0]  w_bcnt;
    logic        w_wdone;
    logic [11:0] w_rxd;
    logic        w_rxv;
    logic        w_ovr;

    int vectors = 0;
    int miscompares = 0;

    spi_shift_engine #(.WIDTH(8), .COUNT_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .periph_clk_edge(edge_p),
        .parallel_load(load), .parallel_in(pin), .lsb_first(lsb),
        .serial_in(sin), .rx_ack(ack), .serial_out(sout),
        .parallel_out(pout), .bit_count(bcnt), .word_done(wdone),
        .rx_data(rxd), .rx_valid(rxv), .overrun(ovr)
    );

    spi_shift_engine #(.WIDTH(12), .COUNT_WIDTH(4)) dut12 (
        .clk(clk), .reset(reset), .periph_clk_edge(w_edge),
        .parallel_load(w_load), .parallel_in(w_pin), .lsb_first(w_lsb),
        .serial_in(w_sin), .rx_ack(w_ack), .serial_out(w_sout),
        .parallel_out(w_pout), .bit_count(w_bcnt), .word_done(w_wdone),
        .rx_data(w_rxd), .rx_valid(w_rxv), .overrun(w_ovr)
    );

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v, input logic l);
        load = 1'b1; pin = v; lsb = l;
        tick();
        load = 1'b0;
    endtask

    // Shift one full word MSB-first; optionally ack on the final edge
    task automatic shift_word(input logic [7:0] v, input logic ack_last);
        for (int i = 0; i < 8; i++) begin
            edge_p = 1'b1;
            sin = v[7-i];
            ack = ack_last && (i == 7);
            tick();
        end
        edge_p = 1'b0;
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if ({sout, pout, bcnt, wdone, rxd, rxv, ovr} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset8: got so=%b po=%h bc=%0d wd=%b rx=%h rv=%b ov=%b, want all 0",
                     sout, pout, bcnt, wdone, rxd, rxv, ovr);
        end
        vectors++;
        if ({w_sout, w_pout, w_bcnt, w_wdone, w_rxd, w_rxv, w_ovr} !== 32'd0) begin
            miscompares++;
            $display("FAIL reset12: got po=%h bc=%0d rx=%h rv=%b, want all 0",
                     w_pout, w_bcnt, w_rxd, w_rxv);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] exp_so = 8'hA5;
        logic [7:0] data = 8'h3C;
        do_load(8'hA5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (sout !== exp_so[7-i]) begin
                miscompares++;
                $display("FAIL msb_so[%0d]: got %b want %b", i, sout, exp_so[7-i]);
            end
            edge_p = 1'b1; sin = data[7-i];
            tick();
            edge_p = 1'b0;
            vectors++;
            if (bcnt !== 3'((i + 1) % 8) || wdone !== (i == 7)) begin
                miscompares++;
                $display("FAIL msb_cnt[%0d]: got bc=%0d wd=%b want bc=%0d wd=%b",
                         i, bcnt, wdone, (i + 1) % 8, (i == 7));
            end
        end
        vectors++;
        if (rxd !== 8'h3C || rxv !== 1'b1 || ovr !== 1'b0 || pout !== 8'h3C) begin
            miscompares++;
            $display("FAIL msb_rx: got rx=%h rv=%b ov=%b po=%h want 3c 1 0 3c", rxd, rxv, ovr, pout);
        end
        tick();
        vectors++;
        if (wdone !== 1'b0) begin
            miscompares++;
            $display("FAIL msb_wd_pulse: got %b want 0", wdone);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] exp_so = 8'b1111_0000;
        do_load(8'h0F, 1'b1);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (sout !== exp_so[7-i]) begin
                miscompares++;
                $display("FAIL lsb_so[%0d]: got %b want %b", i, sout, exp_so[7-i]);
            end
            edge_p = 1'b1; sin = 1'b1;
            tick();
            edge_p = 1'b0;
        end
        // previous word was never acked, so this completion overruns
        vectors++;
        if (rxd !== 8'hFF || rxv !== 1'b1 || ovr !== 1'b1 || wdone !== 1'b1) begin
            miscompares++;
            $display("FAIL lsb_rx: got rx=%h rv=%b ov=%b wd=%b want ff 1 1 1", rxd, rxv, ovr, wdone);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++;
        if (rxv !== 1'b0 || ovr !== 1'b0 || rxd !== 8'hFF) begin
            miscompares++;
            $display("FAIL lsb_ack: got rv=%b ov=%b rx=%h want 0 0 ff", rxv, ovr, rxd);
        end
    endtask

    task automatic test_overrun();
        do_load(8'h00, 1'b0);
        shift_word(8'h12, 1'b0);
        vectors++;
        if (rxd !== 8'h12 || rxv !== 1'b1 || ovr !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_first: got rx=%h rv=%b ov=%b want 12 1 0", rxd, rxv, ovr);
        end
        shift_word(8'h34, 1'b0);
        vectors++;
        if (rxd !== 8'h34 || rxv !== 1'b1 || ovr !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_second: got rx=%h rv=%b ov=%b want 34 1 1", rxd, rxv, ovr);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++;
        if (rxv !== 1'b0 || ovr !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_ack: got rv=%b ov=%b want 0 0", rxv, ovr);
        end
        // rx_ack while idle must not disturb anything
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++;
        if (rxv !== 1'b0 || ovr !== 1'b0 || rxd !== 8'h34) begin
            miscompares++;
            $display("FAIL ovr_idle_ack: got rv=%b ov=%b rx=%h want 0 0 34", rxv, ovr, rxd);
        end
        shift_word(8'h12, 1'b0);
        shift_word(8'h34, 1'b1);
        vectors++;
        if (rxd !== 8'h34 || rxv !== 1'b1 || ovr !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_coincident: got rx=%h rv=%b ov=%b want 34 1 0", rxd, rxv, ovr);
        end
    endtask

    task automatic test_load_priority();
        for (int i = 0; i < 3; i++) begin
            edge_p = 1'b1; sin = 1'b1;
            tick();
        end
        edge_p = 1'b0;
        vectors++;
        if (bcnt !== 3'd3) begin
            miscompares++;
            $display("FAIL lp_precount: got %0d want 3", bcnt);
        end
        load = 1'b1; pin = 8'h5A; lsb = 1'b0; edge_p = 1'b1; sin = 1'b1;
        tick();
        load = 1'b0; edge_p = 1'b0;
        vectors++;
        if (pout !== 8'h5A || bcnt !== 3'd0 || wdone !== 1'b0 || sout !== 1'b0) begin
            miscompares++;
            $display("FAIL lp_load: got po=%h bc=%0d wd=%b so=%b want 5a 0 0 0", pout, bcnt, wdone, sout);
        end
        vectors++;
        if (rxd !== 8'h34 || rxv !== 1'b1 || ovr !== 1'b0) begin
            miscompares++;
            $display("FAIL lp_rx_kept: got rx=%h rv=%b ov=%b want 34 1 0", rxd, rxv, ovr);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] data = 8'h96;
        do_load(8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            edge_p = 1'b1; sin = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; edge_p = 1'b0;
        vectors++;
        if ({sout, pout, bcnt, wdone, rxd, rxv, ovr} !== 23'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got so=%b po=%h bc=%0d wd=%b rx=%h rv=%b ov=%b, want all 0",
                     sout, pout, bcnt, wdone, rxd, rxv, ovr);
        end
        do_load(8'hC3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            edge_p = 1'b1; sin = data[7-i];
            tick();
            edge_p = 1'b0;
            vectors++;
            if (wdone !== (i == 7)) begin
                miscompares++;
                $display("FAIL mr_wd[%0d]: got %b want %b", i, wdone, (i == 7));
            end
        end
        vectors++;
        if (rxd !== 8'h96 || rxv !== 1'b1 || ovr !== 1'b0) begin
            miscompares++;
            $display("FAIL mr_rx: got rx=%h rv=%b ov=%b want 96 1 0", rxd, rxv, ovr);
        end
    endtask

    task automatic test_width12();
        logic [11:0] exp_so = 12'hABC;
        w_load = 1'b1; w_pin = 12'hABC; w_lsb = 1'b0;
        tick();
        w_load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (w_sout !== exp_so[11-i]) begin
                miscompares++;
                $display("FAIL w12_so[%0d]: got %b want %b", i, w_sout, exp_so[11-i]);
            end
            w_edge = 1'b1; w_sin = 1'b0;
            tick();
            w_edge = 1'b0;
            vectors++;
            if (w_wdone !== (i == 11) || w_bcnt !== 4'((i + 1) % 12)) begin
                miscompares++;
                $display("FAIL w12_cnt[%0d]: got wd=%b bc=%0d want wd=%b bc=%0d",
                         i, w_wdone, w_bcnt, (i == 11), (i + 1) % 12);
            end
        end
        vectors++;
        if (w_rxd !== 12'h000 || w_rxv !== 1'b1 || w_ovr !== 1'b0) begin
            miscompares++;
            $display("FAIL w12_rx: got rx=%h rv=%b ov=%b want 000 1 0", w_rxd, w_rxv, w_ovr);
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overrun();
        test_load_priority();
        test_mid_reset();
        test_width12();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
